// File: rtl/pipe_fetch_pkg.sv
// Shared fetch-stage types: FSM encoding, default reset PC, queue entry layout.
package pipe_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_t;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    // Instruction fetches are always word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pipe_fetch_queue.sv
// Circular instruction queue with push/pop/flush; head is read combinationally.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] store [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push_en;
    logic             pop_en;

    // Flush wins over everything; a pop on an empty queue is a no-op.
    assign push_en = push & ~flush;
    assign pop_en  = pop & ~empty & ~flush;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign head_data = empty ? '0 : store[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push_en) - CW'(pop_en);
        end
    end

    // Entry storage; contents are only visible through head_data when non-empty.
    always_ff @(posedge clk) begin
        if (push_en) store[wr_ptr] <= push_data;
        if (rst) assert (!(push_en && full && !pop_en));
    end

endmodule

// File: rtl/pipe_fetch.sv
// Fetch stage: single-outstanding instruction-memory requester feeding a decode queue.
module pipe_fetch
    import pipe_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter int          QDEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        redir_e,
    input  logic [31:0] redir_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc
);
    localparam int CW = $clog2(QDEPTH) + 1;

    fetch_state_t  state, next_state;
    logic [31:0]   pc, pc_next;
    logic          push, pop, flush;
    fetch_entry_t  push_entry, head_entry;
    logic          q_full, q_empty;
    logic [CW-1:0] q_count;

    assign push_entry = '{pc: mem_addr, inst: mem_rdata};

    fetch_queue #(
        .DEPTH (QDEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (flush),
        .head_data (head_entry),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

    assign mem_req  = (state == ST_REQ);
    assign mem_addr = word_align(pc);
    assign id_valid = (q_count != '0);
    assign id_inst  = head_entry.inst;
    assign id_pc    = head_entry.pc;
    // Redirect masks decode handshake for the cycle.
    assign pop      = ~q_empty & id_ready & ~redir_e;

    // State and fetch PC registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            pc    <= RESET_PC;
        end else begin
            state <= next_state;
            pc    <= pc_next;
        end
    end

    // Next-state, PC update and queue control; redirect has priority over push.
    always_comb begin
        next_state = state;
        pc_next    = pc;
        push       = 1'b0;
        flush      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (redir_e) begin
                    pc_next = word_align(redir_pc);
                    flush   = 1'b1;
                end else if (!q_full) begin
                    next_state = ST_REQ;
                end
            end
            ST_REQ: begin
                if (redir_e) begin
                    pc_next    = word_align(redir_pc);
                    flush      = 1'b1;
                    // Same-cycle ack closes the request; otherwise wait it out in DROP.
                    next_state = mem_ack ? ST_IDLE : ST_DROP;
                end else if (mem_ack) begin
                    push       = 1'b1;
                    pc_next    = pc + 32'd4;
                    next_state = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (redir_e) begin
                    pc_next = word_align(redir_pc);
                    flush   = 1'b1;
                end
                // Stale data from the abandoned request is discarded.
                if (mem_ack) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_pipe_fetch.sv
// Directed self-checking bench for pipe_fetch.
module tb_pipe_fetch;
    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        redir_e;
    logic [31:0] redir_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;

    int checks = 0;
    int errors = 0;

    pipe_fetch #(.RESET_PC(32'h0000_0000), .QDEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .redir_e   (redir_e),
        .redir_pc  (redir_pc),
        .id_valid  (id_valid),
        .id_ready  (id_ready),
        .id_inst   (id_inst),
        .id_pc     (id_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dat(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a request and check its address.
    task automatic wait_req(input logic [31:0] a);
        for (int i = 0; i < 20 && !mem_req; i++) @(negedge clk);
        chk("req_seen", 32'(mem_req), 32'd1);
        chk("mem_addr", mem_addr, a);
    endtask

    // Serve one fetch: ack after 'dly' cycles; optionally check the queue head afterwards.
    task automatic serve(input logic [31:0] a, input int dly, input logic head);
        wait_req(a);
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            chk("addr_stable", mem_addr, a);
            chk("req_held", 32'(mem_req), 32'd1);
        end
        mem_ack   = 1'b1;
        mem_rdata = dat(a);
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        if (head) begin
            chk("head_valid", 32'(id_valid), 32'd1);
            chk("head_pc", id_pc, a);
            chk("head_inst", id_inst, dat(a));
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
        redir_e = 1'b0; redir_pc = 32'h0; id_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_id_valid", 32'(id_valid), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_id_inst", id_inst, 32'h0);
        chk("rst_id_pc", id_pc, 32'h0);
        rst = 1'b1;

        // Streaming with decode always ready.
        id_ready = 1'b1;
        serve(32'h0, 1, 1'b1);
        serve(32'h4, 1, 1'b1);
        serve(32'h8, 1, 1'b1);
        @(negedge clk);
        chk("stream_drained", 32'(id_valid), 32'd0);

        // Decode stalled: queue fills to 4 and fetch stops.
        do_reset();
        id_ready = 1'b0;
        serve(32'h0, 1, 1'b0);
        serve(32'h4, 1, 1'b0);
        serve(32'h8, 1, 1'b0);
        serve(32'hC, 1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("full_no_req", 32'(mem_req), 32'd0);
        end
        chk("full_valid", 32'(id_valid), 32'd1);
        chk("full_head_pc", id_pc, 32'h0);
        chk("full_head_inst", id_inst, dat(32'h0));
        id_ready = 1'b1;
        serve(32'h10, 1, 1'b0);
        for (int i = 0; i < 6; i++) @(negedge clk);
        chk("full_drained", 32'(id_valid), 32'd0);

        // Redirect while IDLE with two entries queued; target is unaligned.
        do_reset();
        id_ready = 1'b0;
        serve(32'h0, 1, 1'b0);
        serve(32'h4, 1, 1'b0);
        chk("idle_q2_valid", 32'(id_valid), 32'd1);
        redir_e = 1'b1; redir_pc = 32'h103;
        @(negedge clk);
        redir_e = 1'b0;
        chk("idle_redir_flush", 32'(id_valid), 32'd0);
        chk("idle_redir_noreq", 32'(mem_req), 32'd0);
        serve(32'h100, 1, 1'b1);

        // Redirect during REQ at 0x20; late ack data must be dropped.
        redir_e = 1'b1; redir_pc = 32'h20;
        @(negedge clk);
        redir_e = 1'b0;
        wait_req(32'h20);
        redir_e = 1'b1; redir_pc = 32'h200;
        @(negedge clk);
        redir_e = 1'b0;
        chk("drop_req_low", 32'(mem_req), 32'd0);
        chk("drop_flushed", 32'(id_valid), 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("drop_still_low", 32'(mem_req), 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = 32'h0;
        chk("drop_no_push", 32'(id_valid), 32'd0);
        chk("drop_inst_hidden", id_inst, 32'h0);
        serve(32'h200, 1, 1'b1);

        // Redirect and ack in the same cycle: no push, back to IDLE.
        wait_req(32'h204);
        mem_ack = 1'b1; mem_rdata = dat(32'h204);
        redir_e = 1'b1; redir_pc = 32'h300;
        @(negedge clk);
        mem_ack = 1'b0; redir_e = 1'b0;
        chk("same_no_push", 32'(id_valid), 32'd0);
        chk("same_idle", 32'(mem_req), 32'd0);
        serve(32'h300, 0, 1'b1);

        // PC wraps past the top of the address space.
        redir_e = 1'b1; redir_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        redir_e = 1'b0;
        serve(32'hFFFF_FFFC, 1, 1'b1);
        serve(32'h0, 1, 1'b0);
        chk("wrap_head_pc", id_pc, 32'hFFFF_FFFC);

        // Reset during REQ abandons it; an ack right after release is ignored.
        wait_req(32'h4);
        rst = 1'b0;
        #1;
        chk("midreq_rst_req", 32'(mem_req), 32'd0);
        chk("midreq_rst_valid", 32'(id_valid), 32'd0);
        chk("midreq_rst_addr", mem_addr, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("post_rst_ack_ignored", 32'(id_valid), 32'd0);
        chk("post_rst_req", 32'(mem_req), 32'd1);
        chk("post_rst_addr", mem_addr, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
